// File: rtl/count_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// count_ctrl_pkg
// Shared types and defaults for the counter control stage.
//   db_state_t     : debounce FSM states
//   DEF_DIV        : default enable period in clock cycles
//   DEF_DB_CYCLES  : default number of stable cycles needed to accept an edge
//   cnt_width()    : smallest counter width that can hold a given maximum value
// -----------------------------------------------------------------------------
package count_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE,
    PRESS_CHK,
    PRESSED,
    RELEASE_CHK
  } db_state_t;

  localparam int DEF_DIV       = 4;
  localparam int DEF_DB_CYCLES = 8;

  // Width needed to represent max_val; never less than one bit so that a
  // degenerate counter (max_val of 0) still has a legal declaration.
  function automatic int cnt_width(input int max_val);
    return (max_val > 1) ? $clog2(max_val + 1) : 1;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// -----------------------------------------------------------------------------
// btn_debounce
// Synchronises a raw mechanical button into the clk domain, debounces it and
// emits a one-cycle pulse for every accepted press.
//   clk       : clock
//   reset     : asynchronous, active-low; clears all state
//   btn_raw   : asynchronous button input, 1 = pressed
//   btn_pulse : one-cycle pulse per accepted press (registered)
// -----------------------------------------------------------------------------
module btn_debounce
  import count_ctrl_pkg::*;
#(
  parameter int DB_CYCLES = DEF_DB_CYCLES
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_raw,
  output logic btn_pulse
);

  localparam int              DB_W    = cnt_width(DB_CYCLES);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DB_CYCLES - 1);
  localparam logic [DB_W-1:0] DB_ONE  = DB_W'(1);

  logic [1:0]      sync_q;
  logic            btn_sync;
  db_state_t       state;
  logic [DB_W-1:0] db_cnt;
  logic            new_press;

  assign btn_sync = sync_q[1];

  // new_press marks the edge that enters PRESSED along the press path; it is
  // delayed one more flop into btn_pulse so the pulse lands DB_CYCLES+2 edges
  // after btn_raw is first sampled high. Returning to PRESSED from
  // RELEASE_CHK (a glitch during a hold) never raises it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q    <= 2'b00;
      state     <= IDLE;
      db_cnt    <= '0;
      new_press <= 1'b0;
      btn_pulse <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments let every flop here sample the values
      // from before this edge, so the FSM sees the old btn_sync and btn_pulse
      // sees the old new_press regardless of statement order.
      sync_q    <= {sync_q[0], btn_raw};
      btn_pulse <= new_press;
      new_press <= 1'b0;

      unique case (state)
        IDLE: begin
          if (btn_sync) begin
            db_cnt <= DB_ONE;
            if (DB_CYCLES == 1) begin
              state     <= PRESSED;
              new_press <= 1'b1;
            end else begin
              state <= PRESS_CHK;
            end
          end
        end

        PRESS_CHK: begin
          if (btn_sync) begin
            db_cnt <= db_cnt + DB_ONE;
            if (db_cnt == DB_LAST) begin
              state     <= PRESSED;
              new_press <= 1'b1;
            end
          end else begin
            db_cnt <= '0;
            state  <= IDLE;
          end
        end

        PRESSED: begin
          if (!btn_sync) begin
            db_cnt <= DB_ONE;
            state  <= (DB_CYCLES == 1) ? IDLE : RELEASE_CHK;
          end
        end

        RELEASE_CHK: begin
          if (!btn_sync) begin
            db_cnt <= db_cnt + DB_ONE;
            if (db_cnt == DB_LAST) state <= IDLE;
          end else begin
            db_cnt <= '0;
            state  <= PRESSED;
          end
        end
      endcase
    end
  end

endmodule

// File: rtl/count_enable_gen.sv
// -----------------------------------------------------------------------------
// count_enable_gen
// Control stage in front of the 4-bit counter: debounces a start/stop button,
// toggles a run state on each accepted press and prescales the clock into
// single-cycle enable pulses for the counter.
//   clk       : clock (same domain as the counter)
//   reset     : asynchronous, active-low; clears all state
//   btn_raw   : asynchronous mechanical button, 1 = pressed
//   clear_req : one-cycle synchronous request to restart the prescaler phase
//   enable    : one-cycle pulse every DIV cycles while running
//   running   : run state, toggles on each accepted press
//   btn_pulse : one-cycle pulse on each accepted press
// -----------------------------------------------------------------------------
module count_enable_gen
  import count_ctrl_pkg::*;
#(
  parameter int DIV       = DEF_DIV,
  parameter int DB_CYCLES = DEF_DB_CYCLES
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_raw,
  input  logic clear_req,
  output logic enable,
  output logic running,
  output logic btn_pulse
);

  localparam int               DIV_W    = cnt_width(DIV - 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);

  logic [DIV_W-1:0] div_cnt;

  btn_debounce #(
    .DB_CYCLES (DB_CYCLES)
  ) u_debounce (
    .clk       (clk),
    .reset     (reset),
    .btn_raw   (btn_raw),
    .btn_pulse (btn_pulse)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) running <= 1'b0;
    else        running <= running ^ btn_pulse;
  end

  // While running, btn_pulse means running is about to drop; clearing the
  // phase on that same edge guarantees div_cnt already reads 0 in the first
  // stopped cycle, so a later restart always begins from a fresh phase.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div_cnt <= '0;
    end else if (!running || clear_req || btn_pulse) begin
      div_cnt <= '0;
    end else if (div_cnt == DIV_LAST) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + DIV_W'(1);
    end
  end

  // Combinational on purpose: clear_req must suppress the enable in the same
  // cycle it is asserted, without adding a cycle of latency.
  assign enable = running && (div_cnt == DIV_LAST) && !clear_req;

endmodule

// File: tb/tb_count_enable_gen.sv
module tb_count_enable_gen;

  logic clk       = 1'b0;
  logic reset     = 1'b0;
  logic btn_raw   = 1'b0;
  logic clear_req = 1'b0;
  logic enable, running, btn_pulse;

  logic btn1   = 1'b0;
  logic clear1 = 1'b0;
  logic enable1, running1, btn_pulse1;

  logic [3:0] count, count1, frozen;
  int pulse_cnt  = 0;
  int pulse_base = 0;
  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  count_enable_gen #(.DIV(4), .DB_CYCLES(8)) u_dut (
    .clk       (clk),
    .reset     (reset),
    .btn_raw   (btn_raw),
    .clear_req (clear_req),
    .enable    (enable),
    .running   (running),
    .btn_pulse (btn_pulse)
  );

  count_enable_gen #(.DIV(1), .DB_CYCLES(1)) u_dut1 (
    .clk       (clk),
    .reset     (reset),
    .btn_raw   (btn1),
    .clear_req (clear1),
    .enable    (enable1),
    .running   (running1),
    .btn_pulse (btn_pulse1)
  );

  // Downstream 4-bit counters fed by each enable output.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)      count <= 4'd0;
    else if (enable) count <= count + 4'd1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)       count1 <= 4'd0;
    else if (enable1) count1 <= count1 + 4'd1;
  end

  always @(posedge clk) if (btn_pulse) pulse_cnt <= pulse_cnt + 1;

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic check_val(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Inputs change just after a rising edge; outputs are sampled on the
  // following falling edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  initial begin
    // Reset state
    repeat (3) sample();
    check_bit("rst_enable",    enable,    1'b0);
    check_bit("rst_running",   running,   1'b0);
    check_bit("rst_btn_pulse", btn_pulse, 1'b0);
    check_val("rst_count",     int'(count), 0);
    reset = 1'b1;
    repeat (4) step();

    // Clean press: btn_raw first sampled at edge 0
    step();
    btn_raw = 1'b1;
    for (int k = 0; k <= 23; k++) begin
      step();
      sample();
      check_bit($sformatf("press1_pulse@%0d", k),   btn_pulse, k == 10);
      check_bit($sformatf("press1_running@%0d", k), running,   k >= 11);
      check_bit($sformatf("press1_enable@%0d", k),  enable,
                (k == 14) || (k == 18) || (k == 22));
    end
    check_val("count_after_3_enables", int'(count), 3);
    check_val("press1_pulse_cnt", pulse_cnt, 1);

    // Release and let the release debounce complete
    btn_raw = 1'b0;
    repeat (14) step();

    // Bounce: five high samples are not enough to accept a press
    pulse_base = pulse_cnt;
    step();
    btn_raw = 1'b1;
    repeat (5) step();
    btn_raw = 1'b0;
    repeat (15) step();
    sample();
    check_val("bounce_no_pulse", pulse_cnt, pulse_base);
    check_bit("bounce_running_kept", running, 1'b1);

    // Stop press with a 3-cycle low glitch while held
    pulse_base = pulse_cnt;
    step();
    btn_raw = 1'b1;
    for (int k = 0; k <= 30; k++) begin
      step();
      btn_raw = !((k >= 14) && (k <= 16));
      sample();
      check_bit($sformatf("stop_pulse@%0d", k),   btn_pulse, k == 10);
      check_bit($sformatf("stop_running@%0d", k), running,   k <= 10);
      if (k >= 11) check_bit($sformatf("stop_enable@%0d", k), enable, 1'b0);
      if (k == 11) begin
        frozen = count;
        check_val("stop_div_cnt", int'(u_dut.div_cnt), 0);
      end
    end
    check_val("stop_count_frozen", int'(count), int'(frozen));
    check_val("glitch_single_pulse", pulse_cnt, pulse_base + 1);

    btn_raw = 1'b0;
    repeat (14) step();

    // Restart; clear_req lands on the cycle where div_cnt == 3
    step();
    btn_raw = 1'b1;
    for (int k = 0; k <= 25; k++) begin
      step();
      clear_req = (k == 18);
      sample();
      check_bit($sformatf("clr_pulse@%0d", k),   btn_pulse, k == 10);
      check_bit($sformatf("clr_running@%0d", k), running,   k >= 11);
      check_bit($sformatf("clr_enable@%0d", k),  enable,    (k == 14) || (k == 22));
    end

    // Asynchronous reset mid-run (div_cnt == 2 here)
    pulse_base = pulse_cnt;
    btn_raw = 1'b0;
    reset   = 1'b0;
    #1;
    check_bit("midrst_enable",    enable,    1'b0);
    check_bit("midrst_running",   running,   1'b0);
    check_bit("midrst_btn_pulse", btn_pulse, 1'b0);
    check_val("midrst_div_cnt",   int'(u_dut.div_cnt), 0);
    check_val("midrst_count",     int'(count), 0);
    sample();
    reset = 1'b1;
    for (int k = 0; k <= 19; k++) begin
      step();
      sample();
      check_bit($sformatf("postrst_enable@%0d", k),  enable,  1'b0);
      check_bit($sformatf("postrst_running@%0d", k), running, 1'b0);
    end
    check_val("postrst_no_pulse", pulse_cnt, pulse_base);

    // DIV=1, DB_CYCLES=1 instance
    step();
    btn1 = 1'b1;
    for (int k = 0; k <= 23; k++) begin
      step();
      sample();
      check_bit($sformatf("div1_pulse@%0d", k),   btn_pulse1, k == 3);
      check_bit($sformatf("div1_running@%0d", k), running1,   k >= 4);
      check_bit($sformatf("div1_enable@%0d", k),  enable1,    k >= 4);
      check_val($sformatf("div1_count@%0d", k),   int'(count1),
                (k >= 4) ? ((k - 4) % 16) : 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
